int_ctl: RTL and testbench
==========================

# int_ctl

Parametrised vectored interrupt controller that sits between peripheral interrupt lines and the CPU core. It replaces the single-line `i_int`/`int_enable` scheme with N maskable, prioritised channels, each configurable as edge- or level-triggered. It presents one request plus a vector address to the CPU and tracks the in-service channel until the CPU signals end-of-interrupt. The CPU programs and reads the block through a small register port.

## Interface

- `N_IRQ`, 8, number of interrupt channels (1..16)
- `VEC_BASE`, 16'h0002, vector address of channel 0
- `VEC_STRIDE`, 2, address distance between consecutive channel vectors
- `i_clk` in 1: system clock
- `i_rst` in 1: reset. One clock; reset is synchronous and active-high.
- `i_ce` in 1: clock enable. When low, all state freezes.
- `i_irq` in N_IRQ: raw interrupt lines, synchronous to `i_clk`
- `o_int` out 1: interrupt request to CPU
- `o_vector` out 16: handler address for the requested channel
- `i_ack` in 1: one-cycle pulse. The CPU takes the interrupt at an instruction boundary.
- `i_eoi` in 1: one-cycle pulse. The CPU returns from the handler.
- `i_cfg_we` in 1: register write strobe
- `i_cfg_addr` in 2: register select
- `i_cfg_wdata` in 16: write data
- `o_cfg_rdata` out 16: read data, registered

## Operation

- Registers, bits above N_IRQ-1 read 0 and ignore writes:
  - addr 0 MASK: 1 = channel enabled
  - addr 1 MODE: 1 = edge, 0 = level
  - addr 2 PENDING: read pending bits. Writing 1 clears an edge-mode bit; writes to level-mode bits are ignored.
  - addr 3 STATUS: bit 15 = in-service active, bits 3:0 = in-service index. Read-only.
- `prev` register holds the last sampled `i_irq`.
- Edge pending is set on `i_irq & ~prev`. Level pending equals the sampled `i_irq`.
- Pending is latched regardless of MASK. Unmasking an already-pending channel raises a request.
- Eligible = PENDING & MASK. The winner is the lowest eligible index.
- States:
  - IDLE:
    - When no channel is in service and eligible ≠ 0, assert `o_int`.
    - `o_vector` = VEC_BASE + winner×VEC_STRIDE, computed as 16-bit wrap-around.
    - `o_vector` re-evaluates every cycle while `o_int` is high, so a higher-priority arrival replaces the vector before ack.
  - On `i_ack` with `o_int` high, go to SERVICE:
    - Capture the index currently shown on `o_vector` as the in-service index.
    - Clear that channel's pending bit if it is edge mode.
    - Deassert `o_int`.
  - SERVICE:
    - `o_int` stays low; there is no nesting.
    - Pending bits continue to latch.
  - On `i_eoi`, return to IDLE.
- `i_ack` while `o_int` is low is ignored. `i_eoi` in IDLE is ignored.
- A level channel that is still high after EOI re-requests. The source must deassert its line before EOI.

## Timing

- Reset values:
  - `o_int`=0, `o_vector`=VEC_BASE, `o_cfg_rdata`=0
  - MASK=0, MODE=0, PENDING=0, `prev`=0
  - state IDLE, in-service index 0
- Reset mid-service drops the in-service state immediately.
- All actions occur only on cycles with `i_ce` high.
- `prev` freezes while `i_ce` is low, so an edge spanning a low-`i_ce` window is detected on the next enabled cycle.
- Latency:
  - Rising `i_irq` at edge k sets PENDING at edge k.
  - `o_int`/`o_vector` are registered and valid after edge k+1, i.e. 2 cycles from line to request.
- `i_ack` at edge k: `o_int` is low after edge k, and the pending clear takes effect at edge k.
- `i_eoi` at edge k with another eligible channel: `o_int` is high after edge k+1.
- A register write takes effect at its edge.
- Reads: `o_cfg_rdata` is valid one cycle after the address is presented, and is updated every cycle regardless of `i_cfg_we`.
- Simultaneous events:
  - A new edge and a W1C of the same bit in the same cycle: set wins.
  - A new edge and an ack-clear of the same bit in the same cycle: set wins, and the channel re-requests after EOI.
  - `i_ack` and `i_eoi` in the same cycle: `i_eoi` is ignored.
- Register writes never affect an already captured in-service index.

## Test plan

- Reset, then MASK=0x01, MODE=0x01, pulse `i_irq[0]` → `o_int`=1 two cycles later, `o_vector`=0x0002. Ack → `o_int`=0 and PENDING=0. EOI → `o_int` stays 0.
- MASK=0xFF, MODE=0xFF, edges on channels 5 and 2 in the same cycle → `o_vector`=0x0006 (2×2+2). Ack, EOI → `o_vector`=0x000C and `o_int`=1 two cycles after EOI.
- With channel 5 requesting, an edge on channel 1 before ack → `o_vector` changes to 0x0004. Ack → STATUS=0x8001.
- Level mode, channel 3 held high through EOI → `o_int` reasserts 2 cycles after EOI. Line dropped before EOI → no reassert.
- Masked edge on channel 4 → PENDING=0x0010 and `o_int`=0. Set MASK bit 4 → `o_int`=1 next cycle. W1C 0x0010 together with a new edge in the same cycle → bit stays set.
- `i_ce` low across a rising edge → no change until `i_ce` returns. Assert `i_rst` during SERVICE → all outputs and registers return to their reset values next cycle.

Source files
------------

// File: rtl/int_ctl.sv
// int_ctl: vectored, prioritised interrupt controller with N maskable
// edge/level channels, single outstanding request and in-service tracking.
module int_ctl #(
  parameter int          N_IRQ      = 8,
  parameter logic [15:0] VEC_BASE   = 16'h0002,
  parameter int          VEC_STRIDE = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ce,
  input  logic [N_IRQ-1:0] i_irq,
  output logic             o_int,
  output logic [15:0]      o_vector,
  input  logic             i_ack,
  input  logic             i_eoi,
  input  logic             i_cfg_we,
  input  logic [1:0]       i_cfg_addr,
  input  logic [15:0]      i_cfg_wdata,
  output logic [15:0]      o_cfg_rdata
);

  typedef enum logic {
    S_IDLE,
    S_SERVICE
  } state_t;

  state_t           state;
  logic [N_IRQ-1:0] mask_r;
  logic [N_IRQ-1:0] mode_r;
  logic [N_IRQ-1:0] pend_r;
  logic [N_IRQ-1:0] prev_r;
  logic [3:0]       vec_idx;
  logic [3:0]       svc_idx;

  logic [N_IRQ-1:0] wmask;
  logic [N_IRQ-1:0] edge_set;
  logic [N_IRQ-1:0] w1c;
  logic [N_IRQ-1:0] ack_clr;
  logic [N_IRQ-1:0] pend_nxt;
  logic [N_IRQ-1:0] eligible;
  logic             take;
  logic [3:0]       winner;
  logic [15:0]      vec_nxt;
  logic [15:0]      rd_mux;
  logic             unused_wdata;

  // Upper write-data bits beyond the channel count are intentionally ignored.
  assign unused_wdata = ^i_cfg_wdata;

  // Next pending state: edge bits are sticky with clears, new edges win over clears.
  always_comb begin
    wmask    = i_cfg_wdata[N_IRQ-1:0];
    edge_set = i_irq & ~prev_r;
    take     = i_ack && o_int;
    w1c      = (i_cfg_we && (i_cfg_addr == 2'd2)) ? (wmask & mode_r) : '0;
    ack_clr  = '0;
    for (int unsigned i = 0; i < N_IRQ; i++) begin
      ack_clr[i] = take && mode_r[i] && (vec_idx == 4'(i));
    end
    pend_nxt = (mode_r & ((pend_r & ~w1c & ~ack_clr) | edge_set))
             | (~mode_r & i_irq);
  end

  // Lowest eligible index wins; scan from the top so the lowest assignment sticks.
  always_comb begin
    eligible = pend_r & mask_r;
    winner   = '0;
    for (int unsigned i = N_IRQ; i > 0; i--) begin
      if (eligible[i-1]) begin
        winner = 4'(i - 1);
      end
    end
    vec_nxt = VEC_BASE + (16'(winner) * 16'(VEC_STRIDE));
  end

  // Register read multiplexer.
  always_comb begin
    rd_mux = '0;
    case (i_cfg_addr)
      2'd0:    rd_mux = 16'(mask_r);
      2'd1:    rd_mux = 16'(mode_r);
      2'd2:    rd_mux = 16'(pend_r);
      default: rd_mux = {(state == S_SERVICE), 11'b0, svc_idx};
    endcase
  end

  // Configuration registers, pending latch, request/service FSM and read port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      mask_r      <= '0;
      mode_r      <= '0;
      pend_r      <= '0;
      prev_r      <= '0;
      vec_idx     <= '0;
      svc_idx     <= '0;
      o_int       <= 1'b0;
      o_vector    <= VEC_BASE;
      o_cfg_rdata <= '0;
    end else if (i_ce) begin
      prev_r      <= i_irq;
      pend_r      <= pend_nxt;
      o_cfg_rdata <= rd_mux;
      if (i_cfg_we && (i_cfg_addr == 2'd0)) mask_r <= wmask;
      if (i_cfg_we && (i_cfg_addr == 2'd1)) mode_r <= wmask;
      if (take) begin
        // Ack takes priority over a coincident EOI; the shown vector is captured.
        state   <= S_SERVICE;
        svc_idx <= vec_idx;
        o_int   <= 1'b0;
      end else begin
        if ((state == S_SERVICE) && i_eoi) state <= S_IDLE;
        if ((state == S_IDLE) && (eligible != '0)) begin
          o_int    <= 1'b1;
          vec_idx  <= winner;
          o_vector <= vec_nxt;
        end else begin
          o_int <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_int_ctl.sv
// Directed bench for int_ctl with an expectation queue drained after each step.
module tb_int_ctl;

  localparam int N = 8;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b0;
  logic         i_ce = 1'b1;
  logic [N-1:0] i_irq = '0;
  logic         o_int;
  logic [15:0]  o_vector;
  logic         i_ack = 1'b0;
  logic         i_eoi = 1'b0;
  logic         i_cfg_we = 1'b0;
  logic [1:0]   i_cfg_addr = '0;
  logic [15:0]  i_cfg_wdata = '0;
  logic [15:0]  o_cfg_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    int          sel;   // 0: o_int, 1: o_vector, 2: o_cfg_rdata
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];

  int_ctl #(.N_IRQ(N), .VEC_BASE(16'h0002), .VEC_STRIDE(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_ce(i_ce), .i_irq(i_irq),
    .o_int(o_int), .o_vector(o_vector), .i_ack(i_ack), .i_eoi(i_eoi),
    .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr), .i_cfg_wdata(i_cfg_wdata),
    .o_cfg_rdata(o_cfg_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic expect_val(input string tag, input int sel, input logic [15:0] val);
    exp_t e;
    e.tag = tag; e.sel = sel; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [15:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       obs = {15'b0, o_int};
        1:       obs = o_vector;
        default: obs = o_cfg_rdata;
      endcase
      n_tests++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: got %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    i_cfg_we = 1'b1; i_cfg_addr = a; i_cfg_wdata = d;
    tick();
    i_cfg_we = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [15:0] v);
    i_cfg_addr = a;
    expect_val(tag, 2, v);
    tick();
    drain();
  endtask

  task automatic pulse_ack();
    i_ack = 1'b1; tick(); i_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    i_eoi = 1'b1; tick(); i_eoi = 1'b0;
  endtask

  task automatic pulse_irq(input logic [N-1:0] b);
    i_irq = b; tick(); i_irq = '0;
  endtask

  initial begin
    // Reset state
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    expect_val("rst_int", 0, 16'h0000);
    expect_val("rst_vec", 1, 16'h0002);
    expect_val("rst_rdata", 2, 16'h0000);
    drain();
    rd_check("rst_mask", 2'd0, 16'h0000);
    rd_check("rst_pend", 2'd2, 16'h0000);

    // Single edge channel 0: two-cycle latency, ack clears, EOI idle
    wr(2'd0, 16'h0001);
    wr(2'd1, 16'h0001);
    pulse_irq(8'h01);
    expect_val("c0_int_k", 0, 16'h0000);
    drain();
    tick();
    expect_val("c0_int_k1", 0, 16'h0001);
    expect_val("c0_vec", 1, 16'h0002);
    drain();
    pulse_ack();
    expect_val("c0_ack_int", 0, 16'h0000);
    drain();
    rd_check("c0_pend", 2'd2, 16'h0000);
    rd_check("c0_status", 2'd3, 16'h8000);
    pulse_eoi();
    tick();
    expect_val("c0_eoi_int", 0, 16'h0000);
    drain();
    rd_check("c0_status_idle", 2'd3, 16'h0000);

    // Channels 5 and 2 together: 2 wins, then 5 after EOI
    wr(2'd0, 16'h00FF);
    wr(2'd1, 16'h00FF);
    pulse_irq(8'h24);
    tick();
    expect_val("p_int", 0, 16'h0001);
    expect_val("p_vec2", 1, 16'h0006);
    drain();
    pulse_ack();
    rd_check("p_pend", 2'd2, 16'h0020);
    pulse_eoi();
    expect_val("p_eoi_k", 0, 16'h0000);
    drain();
    tick();
    expect_val("p_eoi_k1", 0, 16'h0001);
    expect_val("p_vec5", 1, 16'h000C);
    drain();
    pulse_ack();
    pulse_eoi();

    // Higher-priority arrival replaces vector before ack
    pulse_irq(8'h20);
    tick();
    expect_val("pre_vec5", 1, 16'h000C);
    drain();
    pulse_irq(8'h02);
    tick();
    expect_val("pre_vec1", 1, 16'h0004);
    drain();
    pulse_ack();
    rd_check("pre_status", 2'd3, 16'h8001);
    rd_check("pre_pend", 2'd2, 16'h0020);
    pulse_eoi();
    tick();
    expect_val("pre_after_vec", 1, 16'h000C);
    drain();
    pulse_ack();
    pulse_eoi();

    // Level channel 3
    wr(2'd1, 16'h00F7);
    i_irq = 8'h08;
    tick(2);
    expect_val("lvl_int", 0, 16'h0001);
    expect_val("lvl_vec", 1, 16'h0008);
    drain();
    pulse_ack();
    pulse_eoi();
    expect_val("lvl_eoi_k", 0, 16'h0000);
    drain();
    tick();
    expect_val("lvl_reassert", 0, 16'h0001);
    drain();
    pulse_ack();
    i_irq = '0;
    tick();
    pulse_eoi();
    tick(2);
    expect_val("lvl_no_reassert", 0, 16'h0000);
    drain();
    wr(2'd1, 16'h00FF);

    // Masked edge latches; unmask requests; W1C vs new edge
    wr(2'd0, 16'h00EF);
    pulse_irq(8'h10);
    tick();
    expect_val("msk_int", 0, 16'h0000);
    drain();
    rd_check("msk_pend", 2'd2, 16'h0010);
    wr(2'd0, 16'h00FF);
    tick();
    expect_val("unmsk_int", 0, 16'h0001);
    expect_val("unmsk_vec", 1, 16'h000A);
    drain();
    i_irq = 8'h10; i_cfg_we = 1'b1; i_cfg_addr = 2'd2; i_cfg_wdata = 16'h0010;
    tick();
    i_irq = '0; i_cfg_we = 1'b0;
    rd_check("w1c_vs_set", 2'd2, 16'h0010);
    wr(2'd2, 16'h0010);
    rd_check("w1c_clear", 2'd2, 16'h0000);

    // Ack-clear vs new edge on the same channel: re-requests after EOI
    pulse_irq(8'h10);
    tick();
    i_ack = 1'b1; i_irq = 8'h10;
    tick();
    i_ack = 1'b0; i_irq = '0;
    rd_check("ack_vs_set", 2'd2, 16'h0010);
    pulse_eoi();
    tick();
    expect_val("ack_vs_set_int", 0, 16'h0001);
    expect_val("ack_vs_set_vec", 1, 16'h000A);
    drain();
    pulse_ack();
    pulse_eoi();

    // Clock enable low across a rising edge
    tick(2);
    i_ce = 1'b0;
    i_irq = 8'h01;
    tick(3);
    expect_val("ce_frozen", 0, 16'h0000);
    drain();
    i_ce = 1'b1;
    tick();
    i_irq = '0;
    tick();
    expect_val("ce_int", 0, 16'h0001);
    expect_val("ce_vec", 1, 16'h0002);
    drain();

    // Reset mid-service
    wr(2'd0, 16'h0003);
    pulse_ack();
    rd_check("svc_status", 2'd3, 16'h8000);
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    expect_val("rst2_int", 0, 16'h0000);
    expect_val("rst2_vec", 1, 16'h0002);
    expect_val("rst2_rdata", 2, 16'h0000);
    drain();
    rd_check("rst2_status", 2'd3, 16'h0000);
    rd_check("rst2_mask", 2'd0, 16'h0000);
    rd_check("rst2_mode", 2'd1, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
